// File: rtl/drv_conf_pkg.sv
// ============================================================================
// drv_conf_pkg -- shared types/constants for the FC configuration scheduler.
// Revision 1.0
// ============================================================================
`default_nettype none

package drv_conf_pkg;

    localparam int FC_WIDTH = 48;
    localparam int FC_BYTES = 6;

    localparam int BOOT_RST_CYC  = 15;
    localparam int BOOT_CFG_CYC  = 49;
    localparam int BOOT_LAT_CYC  = 6;
    localparam int BOOT_GAP_CYC  = 11;
    localparam int BOOT_READ_CYC = 53;

    // The READFC dump occupies the last FC_WIDTH cycles of the boot sequence.
    localparam int DUMP_START_DEF = BOOT_RST_CYC + BOOT_CFG_CYC + BOOT_LAT_CYC
                                  + BOOT_GAP_CYC + BOOT_READ_CYC - FC_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_CHECK   = 3'd5
    } conf_state_e;

endpackage

`default_nettype wire

// File: rtl/conf_readback_shifter.sv
// ============================================================================
// conf_readback_shifter -- MSB-first serial capture of the READFC dump word.
// Revision 1.0
// ============================================================================
`default_nettype none

module conf_readback_shifter
    import drv_conf_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic                sin_i,
    output logic [FC_WIDTH-1:0] data_o,
    output logic                done_o
);

    logic [FC_WIDTH-1:0] data_q;
    logic [5:0]          bit_cnt_q;

    // Clear restarts the bit count only; the last dump stays visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q    <= '0;
            bit_cnt_q <= '0;
        end else if (clr_i) begin
            bit_cnt_q <= '0;
        end else if (en_i) begin
            data_q    <= {data_q[FC_WIDTH-2:0], sin_i};
            bit_cnt_q <= done_o ? 6'd0 : bit_cnt_q + 6'd1;
        end
    end

    assign done_o = en_i && (bit_cnt_q == 6'(FC_WIDTH - 1));
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/driver_conf_scheduler.sv
// ============================================================================
// driver_conf_scheduler -- applies the FC word in a safe slice window and
// verifies it against the driver readback. Revision 1.0
// ============================================================================
`default_nettype none

module driver_conf_scheduler
    import drv_conf_pkg::*;
#(
    parameter logic [FC_WIDTH-1:0] DEFAULT_CONF = '0,
    parameter int                  DUMP_START   = DUMP_START_DEF,
    parameter int                  MAX_RETRY    = 2
) (
    input  logic                clk_lse,
    input  logic                nrst,
    input  logic                wr_en,
    input  logic [2:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                commit,
    input  logic                slice_idle,
    input  logic                driver_sout,
    output logic [FC_WIDTH-1:0] serialized_conf,
    output logic                new_configuration_ready,
    output logic                conf_busy,
    output logic                conf_ok,
    output logic                conf_error,
    output logic [FC_WIDTH-1:0] readback
);

    localparam int                  RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [7:0]          SETTLE_LAST = 8'(DUMP_START - 1);

    generate
        if (DUMP_START < 1 || DUMP_START > 200) begin : g_dump_start_check
            $error("driver_conf_scheduler: DUMP_START must lie in 1..200");
        end
    endgenerate

    conf_state_e          state_q, state_d;
    logic [FC_WIDTH-1:0]  shadow_q;
    logic [FC_WIDTH-1:0]  active_q, active_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic                 pending_q, pending_d;
    logic                 ready_q;
    logic                 ok_q, ok_d;
    logic                 err_q, err_d;
    logic                 shift_en, shift_clr, shift_done;

    always_ff @(posedge clk_lse or negedge nrst) begin
        if (!nrst) begin
            shadow_q <= DEFAULT_CONF;
        end else begin
            for (int b = 0; b < FC_BYTES; b++) begin
                if (wr_en && (wr_addr == 3'(b))) begin
                    shadow_q[b*8 +: 8] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk_lse or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            active_q  <= DEFAULT_CONF;
            cnt_q     <= '0;
            retry_q   <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pending_q <= pending_d;
            ready_q   <= (state_d == ST_APPLY);
            ok_q      <= ok_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        pending_d = pending_q;
        ok_d      = ok_q;
        err_d     = err_q;
        shift_en  = 1'b0;
        shift_clr = 1'b0;

        if (commit) begin
            err_d = 1'b0;
        end
        // PENDING already owns a request, so a commit there simply merges.
        if (commit && (state_q != ST_IDLE) && (state_q != ST_PENDING)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (slice_idle) begin
                    state_d   = ST_APPLY;
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                end
            end
            ST_APPLY: begin
                ok_d      = 1'b0;
                cnt_d     = '0;
                shift_clr = 1'b1;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                shift_en = 1'b1;
                if (shift_done) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((readback == active_q) || (retry_q == RETRY_LIMIT)) begin
                    if (readback == active_q) begin
                        ok_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    retry_d = '0;
                    state_d = (pending_q || commit) ? ST_PENDING : ST_IDLE;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = ST_APPLY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    conf_readback_shifter u_shifter (
        .clk_i  (clk_lse),
        .rst_ni (nrst),
        .clr_i  (shift_clr),
        .en_i   (shift_en),
        .sin_i  (driver_sout),
        .data_o (readback),
        .done_o (shift_done)
    );

    assign serialized_conf         = active_q;
    assign new_configuration_ready = ready_q;
    assign conf_busy               = (state_q != ST_IDLE);
    assign conf_ok                 = ok_q;
    assign conf_error              = err_q;

endmodule

`default_nettype wire

// File: tb/tb_driver_conf_scheduler.sv
// ============================================================================
// tb_driver_conf_scheduler -- directed bench with a driver SOUT echo model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_driver_conf_scheduler;

    logic        clk_lse = 1'b0;
    logic        nrst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        commit;
    logic        slice_idle;
    logic        driver_sout;
    logic [47:0] serialized_conf;
    logic        new_configuration_ready;
    logic        conf_busy;
    logic        conf_ok;
    logic        conf_error;
    logic [47:0] readback;

    int          n_cmp = 0;
    int          n_err = 0;
    int          pulse_cnt = 0;
    int          base;
    int          k = -1;
    bit          corrupt = 1'b0;
    logic [47:0] echo_word = '0;
    logic [47:0] pulse_word [0:15];

    always #5 clk_lse = ~clk_lse;

    driver_conf_scheduler dut (
        .clk_lse                 (clk_lse),
        .nrst                    (nrst),
        .wr_en                   (wr_en),
        .wr_addr                 (wr_addr),
        .wr_data                 (wr_data),
        .commit                  (commit),
        .slice_idle              (slice_idle),
        .driver_sout             (driver_sout),
        .serialized_conf         (serialized_conf),
        .new_configuration_ready (new_configuration_ready),
        .conf_busy               (conf_busy),
        .conf_ok                 (conf_ok),
        .conf_error              (conf_error),
        .readback                (readback)
    );

    // Driver model: echoes the word it was given, MSB first, from 87 cycles after the pulse.
    initial begin
        driver_sout = 1'b0;
        forever begin
            @(negedge clk_lse);
            if (!nrst) begin
                k = -1;
            end else if (new_configuration_ready) begin
                k = 0;
                echo_word = serialized_conf;
                if (pulse_cnt < 16) pulse_word[pulse_cnt] = serialized_conf;
                pulse_cnt++;
            end else if (k >= 0 && k < 1000) begin
                k++;
            end
            if (k >= 87 && k <= 134) driver_sout = echo_word[134 - k] ^ (corrupt && k == 87);
            else                     driver_sout = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chkw(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_lse);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cyc();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        cyc();
        commit = 1'b1;
        cyc();
        commit = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_lse);
            if (!conf_busy) break;
        end
        chk1(tag, conf_busy, 1'b0);
    endtask

    task automatic wait_k(input int th, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_lse);
            if (k >= th) break;
        end
        chk1(tag, (k >= th), 1'b1);
    endtask

    initial begin
        nrst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; slice_idle = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_lse);
        chkw("rst_conf", serialized_conf, 48'h0);
        chkw("rst_readback", readback, 48'h0);
        chk1("rst_ready", new_configuration_ready, 1'b0);
        chk1("rst_busy", conf_busy, 1'b0);
        chk1("rst_ok", conf_ok, 1'b0);
        chk1("rst_err", conf_error, 1'b0);
        cyc();
        nrst = 1'b1;
        base = pulse_cnt;
        repeat (200) cyc();
        @(negedge clk_lse);
        chkw("idle_no_pulse", 48'(pulse_cnt - base), 48'd0);
        chk1("idle_busy", conf_busy, 1'b0);

        // Basic apply with matching readback
        wr(3'd0, 8'h01); wr(3'd1, 8'h23); wr(3'd2, 8'h45);
        wr(3'd3, 8'h67); wr(3'd4, 8'h89); wr(3'd5, 8'hAB);
        chkw("shadow_not_applied", serialized_conf, 48'h0);
        slice_idle = 1'b1;
        base = pulse_cnt;
        do_commit();
        @(negedge clk_lse);
        chk1("t2_ready_early", new_configuration_ready, 1'b0);
        chk1("t2_busy", conf_busy, 1'b1);
        cyc();
        @(negedge clk_lse);
        chk1("t2_ready_pulse", new_configuration_ready, 1'b1);
        chkw("t2_conf", serialized_conf, 48'hAB8967452301);
        cyc();
        @(negedge clk_lse);
        chk1("t2_ready_one_cycle", new_configuration_ready, 1'b0);
        wait_idle(400, "t2_idle_timeout");
        chk1("t2_ok", conf_ok, 1'b1);
        chk1("t2_err", conf_error, 1'b0);
        chkw("t2_readback", readback, 48'hAB8967452301);
        chkw("t2_pulses", 48'(pulse_cnt - base), 48'd1);

        // Idle writes (including an out-of-range address) leave the active word alone
        wr(3'd0, 8'h5A);
        wr(3'd7, 8'hEE);
        @(negedge clk_lse);
        chkw("wr_idle_conf", serialized_conf, 48'hAB8967452301);

        // Pending indefinitely while the slice is busy
        slice_idle = 1'b0;
        base = pulse_cnt;
        do_commit();
        repeat (500) cyc();
        @(negedge clk_lse);
        chk1("t3_busy_wait", conf_busy, 1'b1);
        chkw("t3_no_pulse", 48'(pulse_cnt - base), 48'd0);
        cyc();
        slice_idle = 1'b1;
        @(negedge clk_lse);
        chk1("t3_ready_early", new_configuration_ready, 1'b0);
        cyc();
        @(negedge clk_lse);
        chk1("t3_ready_pulse", new_configuration_ready, 1'b1);
        chkw("t3_conf", serialized_conf, 48'hAB896745235A);
        wait_idle(400, "t3_idle_timeout");
        chk1("t3_ok", conf_ok, 1'b1);

        // Persistent readback corruption exhausts the retries
        corrupt = 1'b1;
        wr(3'd1, 8'h11);
        base = pulse_cnt;
        do_commit();
        wait_idle(1000, "t4_idle_timeout");
        chkw("t4_pulses", 48'(pulse_cnt - base), 48'd3);
        chk1("t4_err", conf_error, 1'b1);
        chk1("t4_ok", conf_ok, 1'b0);
        chkw("t4_last_word", pulse_word[base + 2], 48'hAB896745115A);
        chkw("t4_readback", readback, 48'h2B896745115A);
        corrupt = 1'b0;

        // Commit during CAPTURE, with a same-cycle byte write, queues one more apply
        base = pulse_cnt;
        do_commit();
        @(negedge clk_lse);
        chk1("t5_err_cleared", conf_error, 1'b0);
        wait_k(100, 300, "t5_capture_timeout");
        cyc();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hFF; commit = 1'b1;
        cyc();
        wr_en = 1'b0; commit = 1'b0;
        wait_idle(1000, "t5_idle_timeout");
        chkw("t5_pulses", 48'(pulse_cnt - base), 48'd2);
        chkw("t5_first_word", pulse_word[base], 48'hAB896745115A);
        chkw("t5_second_word", pulse_word[base + 1], 48'hFF896745115A);
        chkw("t5_conf", serialized_conf, 48'hFF896745115A);
        chkw("t5_readback", readback, 48'hFF896745115A);
        chk1("t5_ok", conf_ok, 1'b1);

        // Asynchronous reset in the middle of SETTLE
        base = pulse_cnt;
        do_commit();
        wait_k(40, 100, "t6_settle_timeout");
        @(negedge clk_lse);
        nrst = 1'b0;
        #1;
        chkw("t6_conf", serialized_conf, 48'h0);
        chkw("t6_readback", readback, 48'h0);
        chk1("t6_ready", new_configuration_ready, 1'b0);
        chk1("t6_busy", conf_busy, 1'b0);
        chk1("t6_ok", conf_ok, 1'b0);
        chk1("t6_err", conf_error, 1'b0);
        repeat (2) cyc();
        nrst = 1'b1;
        repeat (300) cyc();
        @(negedge clk_lse);
        chkw("t6_pulses", 48'(pulse_cnt - base), 48'd1);
        chk1("t6_busy_after", conf_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/driver_conf_scheduler.md
Name: driver_conf_scheduler

Overview:
Owns the drivers' 48-bit function-control (FC) configuration word and decides when it may be applied. The MCU-facing logic writes a byte-addressed shadow copy and issues a commit. The block waits for a safe inter-slice window, then publishes the word on serialized_conf and pulses new_configuration_ready to driver_controller. It then captures the READFC dump on driver_sout, compares it with the applied word, and retries or flags an error.

Parameters:
DEFAULT_CONF, 48'h0, FC word applied out of reset.
DUMP_START, 86, SETTLE-counter value at which the first readback bit is sampled.
MAX_RETRY, 2, re-applications allowed after a readback mismatch before conf_error is raised.

Ports:
clk_lse  input  1  block clock, same domain as driver_controller state logic
nrst  input  1  asynchronous active-low reset
wr_en  input  1  shadow byte write strobe
wr_addr  input  3  byte index; 0 = bits [7:0] ... 5 = bits [47:40]; values 6-7 are ignored
wr_data  input  8  byte to write
commit  input  1  one-cycle request to apply the shadow word
slice_idle  input  1  high while driver_controller is in WAIT_FOR_NEXT_SLICE (safe window)
driver_sout  input  1  selected driver SOUT during the dump phase
serialized_conf  output  48  active FC word fed to driver_controller
new_configuration_ready  output  1  one-cycle apply pulse
conf_busy  output  1  high whenever the state is not IDLE
conf_ok  output  1  last readback matched; sticky until the next APPLY
conf_error  output  1  retries exhausted; sticky until the next commit
readback  output  48  last captured dump word

Behaviour:
- Reset (async, nrst low):
  - shadow = active = DEFAULT_CONF; readback = 0.
  - State IDLE; all counters and the pending flag cleared.
  - new_configuration_ready = 0, conf_ok = 0, conf_error = 0, conf_busy = 0.
  - Reset during any state aborts immediately; no partial apply pulse.
- Shadow writes:
  - Accepted in every state and take effect next cycle.
  - Never alter serialized_conf directly.
  - A wr_en and commit in the same cycle: the commit includes the written byte (shadow updated first, snapshot taken at APPLY).
- States:
  - IDLE:
    - commit -> PENDING; conf_error cleared.
  - PENDING:
    - Wait for slice_idle = 1, then go to APPLY the next cycle.
    - There is no timeout; while slice_idle stays low the block waits indefinitely.
  - APPLY (1 cycle):
    - active <= shadow.
    - new_configuration_ready = 1 for exactly this cycle; it is a registered output.
    - conf_ok <= 0; pending flag cleared.
    - -> SETTLE with cnt = 0.
  - SETTLE:
    - cnt increments each cycle.
    - When cnt == DUMP_START-1 -> CAPTURE with bit counter 0.
  - CAPTURE (48 cycles):
    - readback <= {readback[46:0], driver_sout} each cycle (MSB first).
    - After the 48th bit -> CHECK.
  - CHECK (1 cycle):
    - Match (readback == active): conf_ok <= 1, retry counter <= 0.
    - Mismatch with retry < MAX_RETRY: retry++, -> APPLY with the same active word. The shadow is not re-sampled; a newer shadow waits for the pending path.
    - Mismatch with retry == MAX_RETRY: conf_error <= 1, retry <= 0.
    - Exit when not retrying: -> PENDING if the pending flag is set, else IDLE.
- Commit outside IDLE:
  - A commit while in PENDING merges into the current request; no extra apply.
  - A commit in APPLY/SETTLE/CAPTURE/CHECK sets the pending flag, which is served after CHECK.
  - Multiple commits collapse into one pending flag.
- Width rules:
  - cnt is 8 bits; DUMP_START must satisfy 1 <= DUMP_START <= 200, and this is checked by an elaboration assertion.
  - The bit counter is 6 bits; the retry counter is clog2(MAX_RETRY+1) bits.
- slice_idle dropping after the APPLY pulse has no effect, because driver_controller itself reconfigures.

Decomposition:
- Package drv_conf_pkg holds:
  - the state enum (IDLE, PENDING, APPLY, SETTLE, CAPTURE, CHECK);
  - localparams FC_WIDTH = 48 and FC_BYTES = 6;
  - the boot-sequence cycle constants (15, 49, 6, 11, 53) from which DUMP_START is derived.
- One sub-module, conf_readback_shifter: a 48-bit serial-in capture register with enable, clear and done flag.

Test Plan:
- Reset -> serialized_conf = DEFAULT_CONF, all flags 0, conf_busy = 0; no new_configuration_ready pulse over 200 cycles.
- Write bytes 0-5 = 01,23,45,67,89,AB, commit with slice_idle = 1 -> one pulse exactly 2 cycles after commit; serialized_conf = 48'hAB8967452301; model returns the same word on sout from cnt 86 -> conf_ok = 1.
- Commit with slice_idle = 0 for 500 cycles -> no pulse and conf_busy = 1; raise slice_idle -> pulse on the next cycle.
- Model returns a corrupted bit for every dump, MAX_RETRY = 2 -> 3 pulses total, then conf_error = 1, conf_ok = 0, state IDLE.
- Commit during CAPTURE after writing byte 5 = FF -> the first check completes; exactly one further APPLY carries the new byte.
- nrst pulsed low mid-SETTLE -> outputs return to reset values immediately; no pulse follows without a new commit.
